vga_text_render: RTL
====================

// Module: vga_text_render
// PURPOSE
//  Text-mode pixel stage directly downstream of the VGA timing generator (clk_vga domain).
//  Consumes fetch_cell/fetch_font/load_nshift strobes, cell_addr, vpos and blank from timing.
//  Reads char+attr from text RAM, reads glyph byte from font ROM and shifts 8 px per cell.
//  Adds blink, cursor and RGBI->4:4:4 colour expansion; drives vga_r/g/b.
// PARAMETERS
//  CURSOR_TOP   14  first glyph row (vpos[3:0]) of underline cursor
//  CURSOR_BOT   15  last glyph row of underline cursor (inclusive)
//  BLINK_BIT    5   vga_frame bit gating attribute blink (1 = blinking text hidden)
//  CURSOR_BIT   4   vga_frame bit gating cursor visibility (1 = shown)
// PORTS
//  clk_vga      in   1   pixel clock
//  rst_n        in   1   asynchronous reset, active low
//  fetch_cell   in   1   strobe: cell_addr valid, issue text RAM read
//  fetch_font   in   1   strobe: issue font ROM read
//  load_nshift  in   1   1 = load shifter from fetched data, 0 = shift
//  cell_addr    in   12  text cell address from timing block
//  vpos         in   10  current line; [3:0] = glyph row
//  vga_frame    in   8   frame counter (blink/cursor timebase)
//  vga_blank    in   1   1 = outside active area
//  cursor_en    in   1   1 = cursor enabled
//  cursor_addr  in   12  cell address of cursor
//  txt_addr     out  12  text RAM address (= cell_addr, combinational)
//  txt_data     in   16  text RAM data {attr[15:8], char[7:0]}, valid 1 clk after fetch_cell
//  font_addr    out  12  font ROM address {char_q, vpos[3:0]}, registered
//  font_data    in   8   font ROM byte, MSB = leftmost px, valid 1 clk after fetch_font
//  vga_r/g/b    out  4   colour channels (combinational from shifter/attr regs)
// BEHAVIOUR
//  Reset (async, rst_n=0): all regs 0: char_q, attr_q, font_q, shift, attr_sh, cur_q, cur_sh,
//   cell_q, font_addr, capture-delay flags. vga_r/g/b = 0. Release takes effect at next clk edge.
//  Pipeline per 8-clk cell (hpos[2:0]): 0 fetch_cell; 1 capture; 4 fetch_font; 5 capture; 7 load.
//  - fetch_cell cycle: cell_q<=cell_addr; cap_c<=1. Next cycle (cap_c): char_q<=txt_data[7:0],
//    attr_q<=txt_data[15:8], cur_q<=cursor_en & (cell_q==cursor_addr).
//  - fetch_font cycle: font_addr<={char_q, vpos[3:0]}; cap_f<=1. Next cycle: font_q<=font_data.
//  - load_nshift=1: shift<=glyph, attr_sh<=attr_q, cur_sh<=cur_q; else shift<={shift[6:0],1'b0}.
//  - Pixels of a cell appear on the 8 clks after its load edge (hpos 0..7 of next group).
//  Glyph modifiers at load, in order:
//   g = font_q; if attr_q[7] & vga_frame[BLINK_BIT]: g = 8'h00;
//   if cur_q & vga_frame[CURSOR_BIT] & CURSOR_TOP<=vpos[3:0]<=CURSOR_BOT: g = 8'hFF.
//  Colour: fg = attr_sh[3:0], bg = {1'b0, attr_sh[6:4]}; px = shift[7] ? fg : bg.
//   RGBI {I,R,G,B} -> channel X: {X,I,X,I} (0,5,10,15 levels).
//  vga_blank=1 forces vga_r/g/b=0 regardless of shifter.
//  Boundaries:
//   - load_nshift and fetch strobes simultaneous: each acts independently; load uses pre-edge regs.
//   - No fetch in line (vblank): shifter drains to 0 -> bg of last attr, masked by blank.
//   - cell_q==cursor_addr compares full 12 bits; cursor_addr >= 4096 impossible (no wrap logic).
//   - vpos[3:0] wraps 15->0 naturally; glyph row taken from vpos at fetch_font cycle.
//   - rst_n asserted mid-line: outputs 0 immediately; first valid pixels after next full pipeline.
// TESTING
//  1 txt_data=16'h0741 ('A', attr 07), font_data=8'b1010_0000 row 3 -> px 0,2 = (10,10,10); rest 0.
//  2 attr=8'h1E, font=8'hFF -> 8 px (15,15,5); font=8'h00 -> 8 px (0,0,10).
//  3 attr[7]=1, vga_frame[5]=1 -> cell all bg; vga_frame[5]=0 -> glyph shown.
//  4 cursor_en=1, cursor_addr=cell 5, vga_frame[4]=1, vpos[3:0]=14/15 -> cell 5 all fg; row 13 -> glyph.
//  5 vga_blank=1 with shift=8'hFF, attr=8'h0F -> vga_r/g/b=0 every clk.
//  6 rst_n low at hpos mid-cell -> outputs 0 same cycle; after release, next loaded cell renders right.

Source files
------------

// File: rtl/vga_text_render.sv
// vga_text_render
//   Text-mode pixel stage that sits directly behind the VGA timing generator.
//   Each 8-clock character cell goes through the same steps. The block reads
//   char and attr from text RAM, then reads one glyph row from the font ROM.
//   It applies the blink and cursor overrides, then shifts the glyph out one
//   pixel per clock. Each pixel is coloured through RGBI -> 4:4:4 expansion.
//
// Ports
//   clk_vga, rst_n          pixel clock, async active-low reset
//   fetch_cell, fetch_font  read strobes from the timing block
//   load_nshift             1 = load shifter, 0 = shift left one pixel
//   cell_addr, vpos         text cell address, current line (vpos[3:0] = glyph row)
//   vga_frame               frame counter used as blink/cursor timebase
//   vga_blank               1 = outside active area, forces black
//   cursor_en, cursor_addr  underline cursor enable and cell address
//   txt_addr / txt_data     text RAM port (data one clock after fetch_cell)
//   font_addr / font_data   font ROM port (data one clock after fetch_font)
//   vga_r, vga_g, vga_b     4-bit colour channels
module vga_text_render #(
  parameter int CURSOR_TOP = 14,
  parameter int CURSOR_BOT = 15,
  parameter int BLINK_BIT  = 5,
  parameter int CURSOR_BIT = 4
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        fetch_cell,
  input  logic        fetch_font,
  input  logic        load_nshift,
  input  logic [11:0] cell_addr,
  input  logic [9:0]  vpos,
  input  logic [7:0]  vga_frame,
  input  logic        vga_blank,
  input  logic        cursor_en,
  input  logic [11:0] cursor_addr,
  output logic [11:0] txt_addr,
  input  logic [15:0] txt_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  // The row bounds are widened to 5 bits so that a bound of 15 is not a
  // comparison that always holds.
  localparam logic [4:0] CUR_TOP_5 = 5'(CURSOR_TOP);
  localparam logic [4:0] CUR_BOT_5 = 5'(CURSOR_BOT);

  logic [11:0] cell_q, cell_d;
  logic        cap_c_q, cap_c_d;
  logic [7:0]  char_q, char_d;
  logic [7:0]  attr_q, attr_d;
  logic        cur_q, cur_d;
  logic [11:0] font_addr_q, font_addr_d;
  logic        cap_f_q, cap_f_d;
  logic [7:0]  font_q, font_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  attr_sh_q, attr_sh_d;
  logic        cur_sh_q, cur_sh_d;

  logic [7:0]  glyph;
  logic [4:0]  row5;
  logic        cursor_row;
  logic [3:0]  px;

  assign txt_addr  = cell_addr;
  assign font_addr = font_addr_q;

  always_comb begin
    row5       = {1'b0, vpos[3:0]};
    cursor_row = (row5 >= CUR_TOP_5) && (row5 <= CUR_BOT_5);

    // Blink blanks the glyph first, and the cursor then overrides blink.
    glyph = font_q;
    if (attr_q[7] && vga_frame[BLINK_BIT]) glyph = 8'h00;
    if (cur_q && vga_frame[CURSOR_BIT] && cursor_row) glyph = 8'hFF;

    cell_d      = cell_q;
    cap_c_d     = fetch_cell;
    char_d      = char_q;
    attr_d      = attr_q;
    cur_d       = cur_q;
    font_addr_d = font_addr_q;
    cap_f_d     = fetch_font;
    font_d      = font_q;
    attr_sh_d   = attr_sh_q;
    cur_sh_d    = cur_sh_q;
    shift_d     = {shift_q[6:0], 1'b0};

    if (fetch_cell) cell_d = cell_addr;
    if (cap_c_q) begin
      char_d = txt_data[7:0];
      attr_d = txt_data[15:8];
      cur_d  = cursor_en && (cell_q == cursor_addr);
    end
    if (fetch_font) font_addr_d = {char_q, vpos[3:0]};
    if (cap_f_q) font_d = font_data;

    // Load samples the pre-edge capture registers, so a fetch on the same
    // clock cannot disturb the cell that is being loaded.
    if (load_nshift) begin
      shift_d   = glyph;
      attr_sh_d = attr_q;
      cur_sh_d  = cur_q;
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      cell_q      <= '0;
      cap_c_q     <= 1'b0;
      char_q      <= '0;
      attr_q      <= '0;
      cur_q       <= 1'b0;
      font_addr_q <= '0;
      cap_f_q     <= 1'b0;
      font_q      <= '0;
      shift_q     <= '0;
      attr_sh_q   <= '0;
      cur_sh_q    <= 1'b0;
    end else begin
      cell_q      <= cell_d;
      cap_c_q     <= cap_c_d;
      char_q      <= char_d;
      attr_q      <= attr_d;
      cur_q       <= cur_d;
      font_addr_q <= font_addr_d;
      cap_f_q     <= cap_f_d;
      font_q      <= font_d;
      shift_q     <= shift_d;
      attr_sh_q   <= attr_sh_d;
      cur_sh_q    <= cur_sh_d;
    end
  end

  // The pixel colour is RGBI {I,R,G,B}. Each channel expands to {X,I,X,I},
  // which gives the levels 0, 5, 10 and 15.
  always_comb begin
    px = shift_q[7] ? attr_sh_q[3:0] : {1'b0, attr_sh_q[6:4]};
    if (vga_blank) begin
      vga_r = 4'h0;
      vga_g = 4'h0;
      vga_b = 4'h0;
    end else begin
      vga_r = {px[2], px[3], px[2], px[3]};
      vga_g = {px[1], px[3], px[1], px[3]};
      vga_b = {px[0], px[3], px[0], px[3]};
    end
  end

  // The upper line bits, the attr blink bit after load and the delayed
  // cursor flag do not affect colour. They are kept only so the register
  // set stays complete.
  logic unused_ok;
  assign unused_ok = ^{vpos[9:4], vga_frame, attr_sh_q[7], cur_sh_q};

endmodule
